mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 Parameters, one per line:
- WIDTH, 32, operand and HI/LO width
- MULT_LAT, 5, multiply busy cycles (>=1)
- DIV_LAT, 10, divide busy cycles (>=1)

REQ-002 Ports, one per line:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request strobe for op
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
- a  in  WIDTH  operand A (rs)
- b  in  WIDTH  operand B (rt)
- cancel  in  1  aborts in-flight operation
- busy  out  1  operation in flight
- stall_req  out  1  busy OR (start AND op is 0-3), combinational
- hi  out  WIDTH  committed HI register
- lo  out  WIDTH  committed LO register

Function
REQ-003 States SHALL be IDLE and RUN; a remaining-cycle counter of width clog2(max(MULT_LAT,DIV_LAT)+1) SHALL track RUN.
REQ-004 In IDLE, start with op 0-3 SHALL capture a, b and op, load the counter with MULT_LAT (op 0-1) or DIV_LAT (op 2-3), and enter RUN; busy SHALL be 1 from the next cycle.
REQ-005 In RUN, the counter SHALL decrement each cycle; on the edge where it reaches 0, hi/lo SHALL commit the result and the block SHALL return to IDLE, so busy is high for exactly MULT_LAT or DIV_LAT cycles.
REQ-006 MULT/MULTU SHALL form the 2*WIDTH signed/unsigned product; hi = upper WIDTH bits, lo = lower WIDTH bits.
REQ-007 DIV/DIVU SHALL produce lo = quotient and hi = remainder; signed division SHALL truncate toward zero, with the remainder taking the dividend's sign.
REQ-008 Divide by zero: lo = all ones, hi = a (captured); this SHALL hold for both DIV and DIVU.
REQ-009 Signed overflow (a = most-negative, b = -1, DIV): lo = a, hi = 0.
REQ-010 MTHI/MTLO with start in IDLE SHALL write a to hi/lo on the same edge, with zero latency and no busy.
REQ-011 start in RUN (any op) SHALL be ignored; the upstream pipeline holds the instruction via stall_req.
REQ-012 cancel in RUN SHALL return to IDLE at the next edge without modifying hi/lo; cancel SHALL take priority over completion in the same cycle.
REQ-013 cancel in IDLE SHALL be ignored, and start in the same cycle SHALL still be accepted.
REQ-014 Operands SHALL be sampled only at acceptance; changes to a/b during RUN SHALL NOT affect the result.
REQ-015 hi/lo SHALL change only on commit (REQ-005), on MT (REQ-010), or on reset.
REQ-016 Results SHALL be exact for any WIDTH >= 2; the implementation may be iterative or combinational-plus-delay, provided the cycle timing of REQ-005 holds.

Reset
REQ-017 reset SHALL force IDLE, counter = 0, busy = 0, hi = 0, lo = 0 at the next edge, with priority over start and cancel.
REQ-018 reset during RUN SHALL discard the operation with no hi/lo commit.
REQ-019 stall_req SHALL be 0 while reset is high, regardless of start.

Verification
REQ-020 The bench SHALL cover these directed scenarios (WIDTH = 32, default latencies):
- MULT a=0xFFFFFFFE (-2), b=3: busy for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
- DIV a=-7 (0xFFFFFFF9), b=2: busy for 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=5, b=0: lo=0xFFFFFFFF, hi=0x00000005; DIV a=0x80000000, b=-1: lo=0x80000000, hi=0.
- DIV started, cancel on busy cycle 10 (completion cycle): hi/lo keep prior values, busy=0 next cycle; a new MTLO a=0x1234 is then accepted, so lo=0x1234 next edge.
- MULT in flight, reset asserted on cycle 3: busy=0, hi=lo=0 next edge; a MTHI attempted during RUN before reset is ignored.

Source files
------------

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO result registers, fixed-latency busy window and cancel.
// Results are computed combinationally from captured operands and committed when the countdown expires.
module mdu #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
    localparam int unsigned PROD_W  = 2 * WIDTH;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_is_div;
    logic               r_is_signed;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_commit;
    logic               w_abort;
    logic               w_mt_hi;
    logic               w_mt_lo;
    logic               w_long_op;

    assign w_long_op = (op <= 3'd3);

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        w_abort     = 1'b0;
        w_mt_hi     = 1'b0;
        w_mt_lo     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_long_op) begin
                        w_accept    = 1'b1;
                        w_state_nxt = RUN;
                    end
                    w_mt_hi = (op == 3'd4);
                    w_mt_lo = (op == 3'd5);
                end
            end
            RUN: begin
                // Cancel wins over a completion landing on the same edge
                if (cancel) begin
                    w_abort     = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_commit    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Multiply: extend both operands to 2*WIDTH; the truncated product is exact for both signednesses
    logic [PROD_W-1:0] w_ext_a;
    logic [PROD_W-1:0] w_ext_b;
    logic [PROD_W-1:0] w_prod;

    assign w_ext_a = {{WIDTH{r_is_signed & r_a[WIDTH-1]}}, r_a};
    assign w_ext_b = {{WIDTH{r_is_signed & r_b[WIDTH-1]}}, r_b};
    assign w_prod  = w_ext_a * w_ext_b;

    // Divide on magnitudes, then restore signs (quotient toward zero, remainder follows dividend)
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_div_b;
    logic [WIDTH-1:0] w_q_mag;
    logic [WIDTH-1:0] w_r_mag;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_r;
    logic             w_div_zero;

    assign w_neg_a    = r_is_signed & r_a[WIDTH-1];
    assign w_neg_b    = r_is_signed & r_b[WIDTH-1];
    assign w_mag_a    = w_neg_a ? -r_a : r_a;
    assign w_mag_b    = w_neg_b ? -r_b : r_b;
    assign w_div_zero = (r_b == '0);
    assign w_div_b    = w_div_zero ? WIDTH'(1) : w_mag_b;
    assign w_q_mag    = w_mag_a / w_div_b;
    assign w_r_mag    = w_mag_a % w_div_b;
    assign w_q        = (w_neg_a ^ w_neg_b) ? -w_q_mag : w_q_mag;
    assign w_r        = w_neg_a ? -w_r_mag : w_r_mag;

    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    always_comb begin
        w_res_hi = w_prod[PROD_W-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            if (w_div_zero) begin
                w_res_hi = r_a;
                w_res_lo = '1;
            end else begin
                w_res_hi = w_r;
                w_res_lo = w_q;
            end
        end
    end

    // Operand capture and countdown
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_is_div    <= 1'b0;
            r_is_signed <= 1'b0;
        end else if (w_accept) begin
            r_cnt       <= op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
            r_a         <= a;
            r_b         <= b;
            r_is_div    <= op[1];
            r_is_signed <= ~op[0];
        end else if (w_abort) begin
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Architectural HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_commit) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end else begin
            if (w_mt_hi) r_hi <= a;
            if (w_mt_lo) r_lo <= a;
        end
    end

    assign busy      = (r_state == RUN);
    assign stall_req = ~reset & (busy | (start & w_long_op));
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu at WIDTH=32 with default latencies.
module tb_mdu;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_assert = 0;
    int n_fail   = 0;

    mdu dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .cancel    (cancel),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue a long op, check busy/stall/HI/LO hold for lat cycles, then busy drop
    task automatic run_op(input string tag, input logic [2:0] op_i, input logic [31:0] a_i,
                          input logic [31:0] b_i, input int lat,
                          input logic [31:0] hold_hi, input logic [31:0] hold_lo);
        start = 1'b1; op = op_i; a = a_i; b = b_i;
        #1;
        chk({tag, "_stall_req"}, 32'(stall_req), 32'd1);
        step();
        start = 1'b0; a = 32'h5A5A_5A5A; b = 32'h0000_0001;
        for (int i = 0; i < lat; i++) begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_hold_hi"}, hi, hold_hi);
            chk({tag, "_hold_lo"}, lo, hold_lo);
            step();
        end
        chk({tag, "_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; op = 3'd0; a = 32'd1; b = 32'd1; cancel = 1'b0;
        #1;
        chk("rst_stall", 32'(stall_req), 32'd0);
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        reset = 1'b0; start = 1'b0;

        run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'd0, 32'd0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);

        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFE, 32'h0000_0001);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        chk("div_lo", lo, 32'hFFFF_FFFD);

        run_op("div_negb", 3'd2, 32'd7, 32'hFFFF_FFFE, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        chk("div_negb_hi", hi, 32'h0000_0001);
        chk("div_negb_lo", lo, 32'hFFFF_FFFD);

        run_op("divu_z", 3'd3, 32'd5, 32'd0, 10, 32'h0000_0001, 32'hFFFF_FFFD);
        chk("divu_z_hi", hi, 32'h0000_0005);
        chk("divu_z_lo", lo, 32'hFFFF_FFFF);

        run_op("div_z", 3'd2, 32'hFFFF_FFFD, 32'd0, 10, 32'h0000_0005, 32'hFFFF_FFFF);
        chk("div_z_hi", hi, 32'hFFFF_FFFD);
        chk("div_z_lo", lo, 32'hFFFF_FFFF);

        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        chk("div_ovf_hi", hi, 32'h0000_0000);
        chk("div_ovf_lo", lo, 32'h8000_0000);

        run_op("divu", 3'd3, 32'd100, 32'd7, 10, 32'h0000_0000, 32'h8000_0000);
        chk("divu_hi", hi, 32'd2);
        chk("divu_lo", lo, 32'd14);

        // Cancel on the completion cycle
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk("cancel_busy10", 32'(busy), 32'd1);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("cancel_busy", 32'(busy), 32'd0);
        chk("cancel_hi", hi, 32'd2);
        chk("cancel_lo", lo, 32'd14);

        // MTLO accepted in IDLE even with cancel high
        start = 1'b1; op = 3'd5; a = 32'h0000_1234; cancel = 1'b1;
        #1;
        chk("mtlo_stall", 32'(stall_req), 32'd0);
        step();
        start = 1'b0; cancel = 1'b0;
        chk("mtlo_lo", lo, 32'h0000_1234);
        chk("mtlo_hi", hi, 32'd2);
        chk("mtlo_busy", 32'(busy), 32'd0);

        start = 1'b1; op = 3'd4; a = 32'h0000_ABCD;
        step();
        start = 1'b0;
        chk("mthi_hi", hi, 32'h0000_ABCD);
        chk("mthi_lo", lo, 32'h0000_1234);

        start = 1'b1; op = 3'd6; a = 32'hDEAD_0000;
        #1;
        chk("nop_stall", 32'(stall_req), 32'd0);
        step();
        start = 1'b0;
        chk("nop_busy", 32'(busy), 32'd0);
        chk("nop_hi", hi, 32'h0000_ABCD);
        chk("nop_lo", lo, 32'h0000_1234);

        // MULT interrupted by reset; MTHI during RUN is ignored
        start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
        step();
        op = 3'd4; a = 32'hDEAD_BEEF;
        #1;
        chk("run_mthi_stall", 32'(stall_req), 32'd1);
        step();
        start = 1'b0;
        chk("run_mthi_hi", hi, 32'h0000_ABCD);
        chk("run_busy2", 32'(busy), 32'd1);
        step();
        chk("run_busy3", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rrun_busy", 32'(busy), 32'd0);
        chk("rrun_hi", hi, 32'd0);
        chk("rrun_lo", lo, 32'd0);
        for (int i = 0; i < 4; i++) step();
        chk("rrun_nocommit_lo", lo, 32'd0);
        chk("rrun_nocommit_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
